oled_region_sched: RTL and testbench
====================================

OLED_REGION_SCHED -- requirements
Module: oled_region_sched

Interface
REQ-001 SHALL have parameter c_x_bits, default 7, X coordinate width (128-pixel panel).
REQ-002 SHALL have parameter c_y_bits, default 7, Y coordinate width.
REQ-003 SHALL have parameter c_color_bits, default 16, pixel width; 16 sends two bytes, 8 sends one byte.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-006 SHALL have port init_done  in  1  panel init sequence finished; no grant while low.
REQ-007 SHALL have port req  in  2  per-requester region update request, level, held until gnt.
REQ-008 SHALL have ports req_x0, req_x1  in  2*c_x_bits  per-requester column bounds, inclusive.
REQ-009 SHALL have ports req_y0, req_y1  in  2*c_y_bits  per-requester row bounds, inclusive.
REQ-010 SHALL have port gnt  out  2  one-hot, one-cycle pulse when a request is accepted.
REQ-011 SHALL have port done  out  2  one-hot, one-cycle pulse after the last byte of that region is accepted.
REQ-012 SHALL have port busy  out  1  high from grant through done.
REQ-013 SHALL have ports tx_valid  out  1, tx_byte  out  8, tx_dc  out  1: byte to the SPI shifter.
REQ-014 SHALL have port tx_ready  in  1  shifter can accept a byte.
REQ-015 SHALL have ports fb_rd  out  1, fb_x  out  c_x_bits, fb_y  out  c_y_bits: framebuffer read strobe and address.
REQ-016 SHALL have port fb_data  in  c_color_bits  read data, valid exactly 1 cycle after fb_rd.

Function
REQ-017 SHALL use states IDLE -> CMD -> FETCH -> PIX -> (FETCH | FIN) -> IDLE.
REQ-018 IDLE: with init_done=1 and any req bit set, SHALL grant round-robin, favouring the requester not granted last; requester 0 wins the first contention after reset.
REQ-019 At grant SHALL latch the coordinates; if x0>x1 or y0>y1, SHALL swap that pair.
REQ-020 CMD SHALL send 7 bytes in order: 0x15, x0, x1, 0x75, y0, y1, 0x5C; tx_dc=0 for 0x15/0x75/0x5C, tx_dc=1 for parameters.
REQ-021 A byte transfers only on a cycle with tx_valid=1 and tx_ready=1; tx_byte and tx_dc SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-022 FETCH SHALL pulse fb_rd for one cycle with the current pixel address, then capture fb_data on the following cycle.
REQ-023 PIX SHALL send fb_data[15:8] then fb_data[7:0] (16-bit) or fb_data[7:0] (8-bit), all with tx_dc=1.
REQ-024 Pixel order SHALL be raster within the window: x from x0 to x1, then x returns to x0 and y increments, ending at (x1,y1).
REQ-025 At most one fb_rd SHALL be issued per pixel, regardless of backpressure.
REQ-026 FIN SHALL pulse done for the served requester and return to IDLE; the next grant comes no earlier than the cycle after done.
REQ-027 A req that drops before its grant SHALL NOT be granted; a req held high during its own service SHALL be re-granted as a new region.
REQ-028 A 1x1 window SHALL send 7 command bytes plus one pixel.
REQ-029 tx_valid SHALL be low in IDLE and in FIN.

Reset
REQ-030 Asserting resetn=0 SHALL asynchronously force IDLE and clear gnt, done, busy, tx_valid and fb_rd, with the round-robin pointer favouring requester 0.
REQ-031 A reset during any state SHALL abandon the region with no done pulse; the requester re-requests.

Structure
REQ-032 Package oled_pkg SHALL hold the command constants (0x15, 0x75, 0x5C) and the state encoding.
REQ-033 Sub-module oled_spi_byte SHALL be instantiated as the tx_* consumer: a mode-0 shifter, MSB first, spi_clk = clk/2, 16 clk cycles per byte, driving spi_csn, spi_clk, spi_mosi, spi_dc.

Verification
REQ-034 init_done=1, req[0] with window (0..1, 0..1), tx_ready=1 SHALL give bytes 15 00 01 75 00 01 5C, then 8 pixel bytes in order (0,0), (1,0), (0,1), (1,1), then done[0] once.
REQ-035 req=2'b11 held SHALL give gnt[0] then gnt[1]; after both complete, req=2'b11 SHALL give gnt[0] again.
REQ-036 req[1] with x0=5, x1=2, y0=y1=3 SHALL give command bytes 15 02 05 75 03 03 5C and 4 pixels.
REQ-037 tx_ready held low for 10 cycles on a pixel high byte SHALL keep tx_byte stable and issue no extra fb_rd; the stream resumes intact.
REQ-038 resetn pulsed low mid-pixel SHALL clear tx_valid/busy immediately with no done pulse; a fresh req SHALL restart with byte 0x15.
REQ-039 init_done=0 with req=2'b01 SHALL produce no gnt; when init_done rises, gnt[0] SHALL pulse next cycle.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants and state encoding for the OLED region scheduler.
package oled_pkg;

  // SSD1351-style window / write-RAM opcodes
  localparam logic [7:0] c_cmd_set_col = 8'h15;
  localparam logic [7:0] c_cmd_set_row = 8'h75;
  localparam logic [7:0] c_cmd_wr_ram  = 8'h5C;

  // command phase counts down from here to zero, one byte per step
  localparam logic [2:0] c_cmd_last_idx = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_FETCH = 3'd2,
    S_PIX   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  function automatic logic [1:0] onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/oled_spi_byte.sv
// Mode-0 byte shifter: MSB first, spi_clk = clk/2, 16 clk cycles per byte.
module oled_spi_byte (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ld_valid,
  input  logic [7:0] ld_byte,
  input  logic       ld_dc,
  output logic       ld_ready,
  output logic       spi_csn,
  output logic       spi_clk,
  output logic       spi_mosi,
  output logic       spi_dc
);

  logic       busy_q;
  logic       sclk_q;
  logic       dc_q;
  logic [3:0] cnt_q;
  logic [7:0] sh_q;

  // load a byte when idle, then toggle sclk 16 times; shift on each falling edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      dc_q   <= 1'b0;
      cnt_q  <= 4'd0;
      sh_q   <= 8'h00;
    end else if (!busy_q) begin
      sclk_q <= 1'b0;
      if (ld_valid) begin
        busy_q <= 1'b1;
        sh_q   <= ld_byte;
        dc_q   <= ld_dc;
        cnt_q  <= 4'd15;
      end
    end else begin
      sclk_q <= ~sclk_q;
      if (sclk_q) sh_q <= {sh_q[6:0], 1'b0};
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q == 4'd0) busy_q <= 1'b0;
    end
  end

  assign ld_ready = ~busy_q;
  assign spi_csn  = ~busy_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = sh_q[7];
  assign spi_dc   = dc_q;

endmodule

// File: rtl/oled_region_sched.sv
// Two-requester OLED window scheduler: arbitrates, emits the window
// command, then streams framebuffer pixels in raster order to the shifter.
//
// state   | meaning
// IDLE    | waiting for init_done and a request; grants round-robin
// CMD     | sending 15 x0 x1 75 y0 y1 5C
// FETCH   | fb_rd pulse, then capture fb_data the following cycle
// PIX     | sending the captured pixel (1 or 2 bytes)
// FIN     | one-cycle done pulse for the served requester
module oled_region_sched
  import oled_pkg::*;
#(
  parameter int c_x_bits     = 7,
  parameter int c_y_bits     = 7,
  parameter int c_color_bits = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      init_done,
  input  logic [1:0]                req,
  input  logic [2*c_x_bits-1:0]     req_x0,
  input  logic [2*c_x_bits-1:0]     req_x1,
  input  logic [2*c_y_bits-1:0]     req_y0,
  input  logic [2*c_y_bits-1:0]     req_y1,
  output logic [1:0]                gnt,
  output logic [1:0]                done,
  output logic                      busy,
  output logic                      tx_valid,
  output logic [7:0]                tx_byte,
  output logic                      tx_dc,
  input  logic                      tx_ready,
  output logic                      fb_rd,
  output logic [c_x_bits-1:0]       fb_x,
  output logic [c_y_bits-1:0]       fb_y,
  input  logic [c_color_bits-1:0]   fb_data,
  output logic                      spi_csn,
  output logic                      spi_clk,
  output logic                      spi_mosi,
  output logic                      spi_dc
);

  localparam logic c_two_bytes = (c_color_bits > 8);

  state_t state_q, state_d;

  logic                    last_q;
  logic                    owner_q;
  logic [1:0]              gnt_q;
  logic [c_x_bits-1:0]     x0_q, x1_q, cx_q;
  logic [c_y_bits-1:0]     y0_q, y1_q, cy_q;
  logic [2:0]              cmd_cnt_q;
  logic                    fetch_ph_q;
  logic [c_color_bits-1:0] pix_q;
  logic                    pix_hi_q;

  logic                    sh_ready;
  logic                    xfer;
  logic                    grant_any;
  logic                    grant_sel;
  logic                    last_pix;
  logic [15:0]             pix16;
  logic [c_x_bits-1:0]     gx0, gx1, gx_lo, gx_hi;
  logic [c_y_bits-1:0]     gy0, gy1, gy_lo, gy_hi;

  // the shifter's own readiness gates the handshake alongside tx_ready
  assign xfer      = tx_valid & tx_ready & sh_ready;
  assign grant_any = init_done & (|req);
  // on contention favour the requester not granted last
  assign grant_sel = (req == 2'b11) ? ~last_q : req[1];
  assign last_pix  = (cx_q == x1_q) && (cy_q == y1_q);
  assign pix16     = 16'(pix_q);

  // selected requester's window, normalised so lo <= hi on each axis
  always_comb begin
    gx0   = grant_sel ? req_x0[2*c_x_bits-1 -: c_x_bits] : req_x0[c_x_bits-1:0];
    gx1   = grant_sel ? req_x1[2*c_x_bits-1 -: c_x_bits] : req_x1[c_x_bits-1:0];
    gy0   = grant_sel ? req_y0[2*c_y_bits-1 -: c_y_bits] : req_y0[c_y_bits-1:0];
    gy1   = grant_sel ? req_y1[2*c_y_bits-1 -: c_y_bits] : req_y1[c_y_bits-1:0];
    gx_lo = (gx0 > gx1) ? gx1 : gx0;
    gx_hi = (gx0 > gx1) ? gx0 : gx1;
    gy_lo = (gy0 > gy1) ? gy1 : gy0;
    gy_hi = (gy0 > gy1) ? gy0 : gy1;
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // next state and byte-stream outputs; tx_byte/tx_dc depend only on
  // registered state so they hold while a byte waits for acceptance
  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    tx_dc    = 1'b1;
    fb_rd    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_any) state_d = S_CMD;
      end
      S_CMD: begin
        tx_valid = 1'b1;
        case (cmd_cnt_q)
          3'd6:    begin tx_byte = c_cmd_set_col; tx_dc = 1'b0; end
          3'd5:    tx_byte = 8'(x0_q);
          3'd4:    tx_byte = 8'(x1_q);
          3'd3:    begin tx_byte = c_cmd_set_row; tx_dc = 1'b0; end
          3'd2:    tx_byte = 8'(y0_q);
          3'd1:    tx_byte = 8'(y1_q);
          default: begin tx_byte = c_cmd_wr_ram; tx_dc = 1'b0; end
        endcase
        if (xfer && (cmd_cnt_q == 3'd0)) state_d = S_FETCH;
      end
      S_FETCH: begin
        fb_rd = ~fetch_ph_q;
        if (fetch_ph_q) state_d = S_PIX;
      end
      S_PIX: begin
        tx_valid = 1'b1;
        tx_byte  = pix_hi_q ? pix16[15:8] : pix16[7:0];
        if (xfer && !pix_hi_q) state_d = last_pix ? S_FIN : S_FETCH;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // grant latch, window counters, command counter and pixel capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      gnt_q      <= 2'b00;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      cmd_cnt_q  <= 3'd0;
      fetch_ph_q <= 1'b0;
      pix_q      <= '0;
      pix_hi_q   <= 1'b0;
    end else begin
      gnt_q <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (grant_any) begin
            owner_q    <= grant_sel;
            last_q     <= grant_sel;
            gnt_q      <= onehot2(grant_sel);
            x0_q       <= gx_lo;
            x1_q       <= gx_hi;
            y0_q       <= gy_lo;
            y1_q       <= gy_hi;
            cx_q       <= gx_lo;
            cy_q       <= gy_lo;
            cmd_cnt_q  <= c_cmd_last_idx;
            fetch_ph_q <= 1'b0;
          end
        end
        S_CMD: begin
          if (xfer) cmd_cnt_q <= cmd_cnt_q - 3'd1;
        end
        S_FETCH: begin
          fetch_ph_q <= ~fetch_ph_q;
          if (fetch_ph_q) begin
            pix_q    <= fb_data;
            pix_hi_q <= c_two_bytes;
          end
        end
        S_PIX: begin
          if (xfer) begin
            if (pix_hi_q) begin
              pix_hi_q <= 1'b0;
            end else if (!last_pix) begin
              if (cx_q == x1_q) begin
                cx_q <= x0_q;
                cy_q <= cy_q + c_y_bits'(1);
              end else begin
                cx_q <= cx_q + c_x_bits'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = (state_q == S_FIN) ? onehot2(owner_q) : 2'b00;
  assign busy = (state_q != S_IDLE);
  assign fb_x = cx_q;
  assign fb_y = cy_q;

  oled_spi_byte u_spi (
    .clk      (clk),
    .resetn   (resetn),
    .ld_valid (tx_valid & tx_ready),
    .ld_byte  (tx_byte),
    .ld_dc    (tx_dc),
    .ld_ready (sh_ready),
    .spi_csn  (spi_csn),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_dc   (spi_dc)
  );

endmodule

// File: tb/tb_oled_region_sched.sv
// Scoreboard bench: expected grants, SPI bytes and dones are queued by the
// stimulus; monitors decode the SPI wires and pop/compare independently.
module tb_oled_region_sched;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        init_done = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [13:0] req_x0 = '0, req_x1 = '0, req_y0 = '0, req_y1 = '0;
  logic        tx_ready = 1'b1;
  logic [15:0] fb_data = 16'h0000;
  logic [1:0]  gnt, done;
  logic        busy, tx_valid, tx_dc, fb_rd;
  logic [7:0]  tx_byte;
  logic [6:0]  fb_x, fb_y;
  logic        spi_csn, spi_clk, spi_mosi, spi_dc;

  int n_checks = 0;
  int n_fail   = 0;
  int fb_cnt   = 0;

  logic [8:0] exp_bytes[$];
  logic [1:0] exp_gnt[$];
  logic [1:0] exp_done[$];

  oled_region_sched dut (
    .clk(clk), .resetn(resetn), .init_done(init_done), .req(req),
    .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
    .gnt(gnt), .done(done), .busy(busy),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_dc(tx_dc), .tx_ready(tx_ready),
    .fb_rd(fb_rd), .fb_x(fb_x), .fb_y(fb_y), .fb_data(fb_data),
    .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_dc(spi_dc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pix_of(input logic [6:0] x, input logic [6:0] y);
    return {1'b1, y, 1'b0, x};
  endfunction

  // framebuffer: data valid exactly one cycle after fb_rd
  always @(posedge clk) fb_data <= fb_rd ? pix_of(fb_x, fb_y) : 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s timed out", name);
  endtask

  // SPI decoder: sample MOSI on each rising spi_clk, seen at clk negedges
  logic       sclk_prev = 1'b0;
  logic [7:0] rx_sh = 8'h00;
  int         rx_bits = 0;
  always @(negedge clk) begin
    if (!resetn) begin
      rx_bits   = 0;
      sclk_prev = 1'b0;
    end else begin
      if (spi_clk && !sclk_prev && !spi_csn) begin
        rx_sh = {rx_sh[6:0], spi_mosi};
        rx_bits++;
        if (rx_bits == 8) begin
          rx_bits = 0;
          if (exp_bytes.size() == 0) chk("spi_byte_unexpected", {spi_dc, rx_sh}, 9'h1FF);
          else                       chk("spi_byte", {spi_dc, rx_sh}, exp_bytes.pop_front());
        end
      end
      sclk_prev = spi_clk;
    end
  end

  // grant / done / fb_rd monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (fb_rd) fb_cnt++;
      if (gnt != 2'b00) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", gnt, 2'b00);
        else                     chk("gnt", gnt, exp_gnt.pop_front());
      end
      if (done != 2'b00) begin
        if (exp_done.size() == 0) chk("done_unexpected", done, 2'b00);
        else                      chk("done", done, exp_done.pop_front());
      end
    end
  end

  task automatic pb(input logic [8:0] b);
    exp_bytes.push_back(b);
  endtask

  task automatic set_win(input int r, input int x0, input int x1, input int y0, input int y1);
    req_x0[r*7 +: 7] = 7'(x0);
    req_x1[r*7 +: 7] = 7'(x1);
    req_y0[r*7 +: 7] = 7'(y0);
    req_y1[r*7 +: 7] = 7'(y1);
  endtask

  // small reference model for windows built from parameters
  task automatic push_region(input int r, input int x0, input int x1,
                             input int y0, input int y1, output int npix);
    int xl, xh, yl, yh;
    logic [15:0] p;
    xl = (x0 > x1) ? x1 : x0;  xh = (x0 > x1) ? x0 : x1;
    yl = (y0 > y1) ? y1 : y0;  yh = (y0 > y1) ? y0 : y1;
    exp_gnt.push_back(r[0] ? 2'b10 : 2'b01);
    pb(9'h015); pb({1'b1, 8'(xl)}); pb({1'b1, 8'(xh)});
    pb(9'h075); pb({1'b1, 8'(yl)}); pb({1'b1, 8'(yh)}); pb(9'h05C);
    npix = 0;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) begin
        p = pix_of(7'(x), 7'(y));
        pb({1'b1, p[15:8]});
        pb({1'b1, p[7:0]});
        npix++;
      end
    exp_done.push_back(r[0] ? 2'b10 : 2'b01);
  endtask

  task automatic wait_gnt(input int r);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (gnt[r]) return;
    end
    fail_to("wait_gnt");
  endtask

  task automatic wait_done(input int r);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done[r]) return;
    end
    fail_to("wait_done");
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_bytes.size() != 0; i++) @(negedge clk);
    chk("bytes_drained", exp_bytes.size(), 0);
  endtask

  task automatic run_req(input int r, input int x0, input int x1,
                         input int y0, input int y1, input int npix);
    int f0;
    f0 = fb_cnt;
    set_win(r, x0, x1, y0, y1);
    req[r] = 1'b1;
    wait_gnt(r);
    req[r] = 1'b0;
    wait_done(r);
    drain();
    chk("fb_rd_per_pixel", fb_cnt - f0, npix);
  endtask

  task automatic wait_fb_rd();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fb_rd) return;
    end
    fail_to("wait_fb_rd");
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, f0, cnt;
    logic [7:0] held;
    logic stable;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_fb_rd", fb_rd, 1'b0);
    chk("rst_spi_csn", spi_csn, 1'b1);
    resetn = 1'b1;
    init_done = 1'b1;
    @(negedge clk);

    // contention: requester 0 first, then 1, then 0 again
    push_region(0, 1, 1, 2, 2, n);
    push_region(1, 4, 4, 6, 6, n2);
    set_win(0, 1, 1, 2, 2);
    set_win(1, 4, 4, 6, 6);
    req = 2'b11;
    wait_gnt(0); req[0] = 1'b0;
    wait_gnt(1); req[1] = 1'b0;
    wait_done(1);
    drain();
    push_region(0, 1, 1, 2, 2, n);
    push_region(1, 4, 4, 6, 6, n2);
    req = 2'b11;
    wait_gnt(0); req[0] = 1'b0;
    wait_gnt(1); req[1] = 1'b0;
    wait_done(1);
    drain();

    // 2x2 window, hand-computed stream
    exp_gnt.push_back(2'b01);
    pb(9'h015); pb(9'h100); pb(9'h101); pb(9'h075); pb(9'h100); pb(9'h101); pb(9'h05C);
    pb(9'h180); pb(9'h100); pb(9'h180); pb(9'h101);
    pb(9'h181); pb(9'h100); pb(9'h181); pb(9'h101);
    exp_done.push_back(2'b01);
    run_req(0, 0, 1, 0, 1, 4);

    // reversed x bounds on requester 1
    exp_gnt.push_back(2'b10);
    pb(9'h015); pb(9'h102); pb(9'h105); pb(9'h075); pb(9'h103); pb(9'h103); pb(9'h05C);
    pb(9'h183); pb(9'h102); pb(9'h183); pb(9'h103);
    pb(9'h183); pb(9'h104); pb(9'h183); pb(9'h105);
    exp_done.push_back(2'b10);
    run_req(1, 5, 2, 3, 3, 4);

    // backpressure on a pixel high byte
    push_region(0, 0, 1, 5, 5, n);
    f0 = fb_cnt;
    set_win(0, 0, 1, 5, 5);
    req[0] = 1'b1;
    wait_gnt(0);
    req[0] = 1'b0;
    wait_fb_rd();
    @(negedge clk);
    @(negedge clk);
    chk("thr_valid", tx_valid, 1'b1);
    chk("thr_hi_byte", tx_byte, 8'h85);
    tx_ready = 1'b0;
    held = tx_byte;
    stable = 1'b1;
    cnt = fb_cnt;
    repeat (10) begin
      @(negedge clk);
      if (!tx_valid || tx_byte !== held || tx_dc !== 1'b1) stable = 1'b0;
    end
    chk("thr_stable", stable, 1'b1);
    chk("thr_no_extra_fb_rd", fb_cnt - cnt, 0);
    tx_ready = 1'b1;
    wait_done(0);
    drain();
    chk("thr_fb_rd_total", fb_cnt - f0, n);

    // no grant while init_done is low
    push_region(0, 7, 7, 8, 8, n);
    set_win(0, 7, 7, 8, 8);
    init_done = 1'b0;
    req = 2'b01;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (gnt != 2'b00) cnt++;
    end
    chk("no_gnt_init_low", cnt, 0);
    init_done = 1'b1;
    @(negedge clk);
    chk("gnt_after_init", gnt, 2'b01);
    req = 2'b00;
    wait_done(0);
    drain();

    // reset in the middle of a pixel
    push_region(0, 0, 3, 0, 0, n);
    f0 = fb_cnt;
    set_win(0, 0, 3, 0, 0);
    req[0] = 1'b1;
    wait_gnt(0);
    req[0] = 1'b0;
    wait_fb_rd();
    wait_fb_rd();
    @(negedge clk);
    @(negedge clk);
    chk("mid_pix_busy", busy, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_tx_valid", tx_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_fb_rd", fb_rd, 1'b0);
    exp_bytes.delete();
    exp_gnt.delete();
    exp_done.delete();
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done != 2'b00) cnt++;
    end
    chk("rst_mid_no_done", cnt, 0);
    resetn = 1'b1;
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done != 2'b00) cnt++;
    end
    chk("post_rst_no_done", cnt, 0);
    push_region(0, 2, 2, 9, 9, n);
    run_req(0, 2, 2, 9, 9, n);

    chk("gnt_queue_empty", exp_gnt.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    chk("byte_queue_empty", exp_bytes.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
